// File: rtl/score_digit_addresser.sv
// score_digit_addresser
// Keeps a 3-digit saturating BCD score. Maps the VGA scan position onto a
// 3-digit score field and drives the addresses for the digit-glyph ROM.
// Ports:
//   clock_25        pixel clock; all state changes on its rising edge
//   reset           synchronous, active-high
//   h_count/v_count current scan position
//   point           score event; only its rising edge counts
//   clear_score     level; zeroes the score while high
//   selected_number glyph index to the ROM; stage 1
//   count           ROM bit index 2*(row*10+col); stage 2
//   digit_active    high when the ROM pixel belongs to a digit; stage 2
//   score_bcd       {hundreds, tens, units}
//   score_max       high while the score is 999
module score_digit_addresser #(
  parameter logic [9:0] ORIGIN_X = 10'd560,
  parameter logic [9:0] ORIGIN_Y = 10'd8,
  parameter int         PITCH    = 12
) (
  input  logic        clock_25,
  input  logic        reset,
  input  logic [9:0]  h_count,
  input  logic [9:0]  v_count,
  input  logic        point,
  input  logic        clear_score,
  output logic [4:0]  selected_number,
  output logic [7:0]  count,
  output logic        digit_active,
  output logic [11:0] score_bcd,
  output logic        score_max
);

  localparam logic [9:0] PITCH_1 = 10'(PITCH);
  localparam logic [9:0] PITCH_2 = 10'(2 * PITCH);
  localparam logic [9:0] FIELD_W = 10'(2 * PITCH + 10);

  logic        point_d;
  logic        inc_req;
  logic [11:0] score_next;

  logic [9:0]  rel_x;
  logic [9:0]  row;
  logic [9:0]  col;
  logic [3:0]  digit;
  logic        in_field;
  logic [7:0]  lin;
  logic [4:0]  sel_next;
  logic [7:0]  cnt_next;
  logic        act_next;

  logic [7:0]  cnt_s1;
  logic        act_s1;

  assign inc_req   = point & ~point_d;
  assign score_max = (score_bcd == 12'h999);

  // Ripple the carries through all three digits in one cycle; 999 holds.
  always_comb begin
    score_next = score_bcd;
    if (inc_req && !score_max) begin
      if (score_bcd[3:0] != 4'd9) begin
        score_next[3:0] = score_bcd[3:0] + 4'd1;
      end else begin
        score_next[3:0] = 4'd0;
        if (score_bcd[7:4] != 4'd9) begin
          score_next[7:4] = score_bcd[7:4] + 4'd1;
        end else begin
          score_next[7:4]  = 4'd0;
          score_next[11:8] = score_bcd[11:8] + 4'd1;
        end
      end
    end
  end

  // Underflow of rel_x/row wraps to large values and falls outside.
  always_comb begin
    rel_x    = h_count - ORIGIN_X;
    row      = v_count - ORIGIN_Y;
    col      = '0;
    digit    = '0;
    lin      = '0;
    sel_next = '0;
    cnt_next = '0;
    act_next = 1'b0;
    in_field = (h_count >= ORIGIN_X) && (rel_x < FIELD_W) && (row < 10'd10);

    if (rel_x < PITCH_1) begin
      col   = rel_x;
      digit = score_bcd[11:8];
    end else if (rel_x < PITCH_2) begin
      col   = rel_x - PITCH_1;
      digit = score_bcd[7:4];
    end else begin
      col   = rel_x - PITCH_2;
      digit = score_bcd[3:0];
    end

    // col >= 10 is the inter-digit gap
    if (in_field && (col < 10'd10)) begin
      lin      = row[7:0] * 8'd10 + col[7:0];
      sel_next = {1'b0, digit};
      cnt_next = {lin[6:0], 1'b0};
      act_next = 1'b1;
    end
  end

  always_ff @(posedge clock_25) begin
    if (reset) begin
      point_d   <= 1'b0;
      score_bcd <= 12'h000;
    end else begin
      point_d <= point;
      if (clear_score) begin
        score_bcd <= 12'h000;
      end else begin
        score_bcd <= score_next;
      end
    end
  end

  // The ROM registers the glyph select but indexes combinationally, so
  // count and digit_active trail selected_number by one extra stage.
  always_ff @(posedge clock_25) begin
    if (reset) begin
      selected_number <= '0;
      cnt_s1          <= '0;
      act_s1          <= 1'b0;
      count           <= '0;
      digit_active    <= 1'b0;
    end else begin
      selected_number <= sel_next;
      cnt_s1          <= cnt_next;
      act_s1          <= act_next;
      count           <= cnt_s1;
      digit_active    <= act_s1;
    end
  end

endmodule

// File: tb/tb_score_digit_addresser.sv
module tb_score_digit_addresser;

  localparam int OX = 560;
  localparam int OY = 8;
  localparam int PI = 12;

  logic        clock_25 = 1'b0;
  logic        reset;
  logic [9:0]  h_count;
  logic [9:0]  v_count;
  logic        point;
  logic        clear_score;
  logic [4:0]  selected_number;
  logic [7:0]  count;
  logic        digit_active;
  logic [11:0] score_bcd;
  logic        score_max;

  score_digit_addresser #(.ORIGIN_X(10'd560), .ORIGIN_Y(10'd8), .PITCH(12)) dut (
    .clock_25(clock_25), .reset(reset), .h_count(h_count), .v_count(v_count),
    .point(point), .clear_score(clear_score), .selected_number(selected_number),
    .count(count), .digit_active(digit_active), .score_bcd(score_bcd),
    .score_max(score_max)
  );

  always #20 clock_25 = ~clock_25;

  typedef struct {
    logic [4:0] sel;
    logic [7:0] cnt;
    logic       act;
  } pix_t;

  typedef struct {
    logic [11:0] bcd;
    logic        max;
  } sc_t;

  pix_t pix_q[$];
  sc_t  sc_q[$];

  int checks = 0;
  int errors = 0;
  int m_score = 0;
  logic m_prev = 1'b0;
  int cyc = 0;

  function automatic logic [11:0] to_bcd(input int s);
    logic [3:0] h, t, u;
    h = 4'(s / 100);
    t = 4'((s / 10) % 10);
    u = 4'(s % 10);
    return {h, t, u};
  endfunction

  function automatic pix_t pix_model(input int h, input int v, input int s);
    pix_t r;
    int rx, ry, d, c, dig;
    r.sel = '0; r.cnt = '0; r.act = 1'b0;
    if (h < OX || v < OY) return r;
    rx = h - OX;
    ry = v - OY;
    if (ry >= 10 || rx >= 2 * PI + 10) return r;
    d = rx / PI;
    c = rx % PI;
    if (d > 2) begin d = 2; c = rx - 2 * PI; end
    if (c >= 10) return r;
    dig = (d == 0) ? s / 100 : (d == 1) ? (s / 10) % 10 : s % 10;
    r.sel = 5'(dig);
    r.cnt = 8'(2 * (ry * 10 + c));
    r.act = 1'b1;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: drive inputs, push model expectations, sample #1 after edge.
  task automatic step(input logic p, input logic clr, input int h, input int v);
    pix_t pe, po;
    sc_t  se, so;
    point = p; clear_score = clr;
    h_count = 10'(h); v_count = 10'(v);
    pe = pix_model(h, v, m_score);
    pix_q.push_back(pe);
    if (clr) m_score = 0;
    else if (p && !m_prev && m_score < 999) m_score++;
    m_prev = p;
    se.bcd = to_bcd(m_score);
    se.max = (m_score == 999);
    sc_q.push_back(se);
    @(posedge clock_25);
    #1;
    cyc++;
    so = sc_q.pop_front();
    chk("score_bcd", 32'(score_bcd), 32'(so.bcd));
    chk("score_max", 32'(score_max), 32'(so.max));
    chk("selected_number", 32'(selected_number), 32'(pix_q[$].sel));
    if (pix_q.size() >= 2) begin
      po = pix_q.pop_front();
      chk("count", 32'(count), 32'(po.cnt));
      chk("digit_active", 32'(digit_active), 32'(po.act));
    end
  endtask

  task automatic do_reset(input int h, input int v);
    pix_t z;
    reset = 1'b1; point = 1'b0; clear_score = 1'b0;
    h_count = 10'(h); v_count = 10'(v);
    @(posedge clock_25);
    #1;
    cyc++;
    reset = 1'b0;
    m_score = 0; m_prev = 1'b0;
    sc_q.delete();
    pix_q.delete();
    z.sel = '0; z.cnt = '0; z.act = 1'b0;
    pix_q.push_back(z);
    chk("rst_sel", 32'(selected_number), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_active", 32'(digit_active), 32'd0);
    chk("rst_score", 32'(score_bcd), 32'd0);
    chk("rst_max", 32'(score_max), 32'd0);
  endtask

  task automatic pulse();
    step(1'b1, 1'b0, 0, 0);
    step(1'b0, 1'b0, 0, 0);
  endtask

  int first_drive;
  int rise_cyc;

  initial begin
    reset = 1'b1; point = 1'b0; clear_score = 1'b0;
    h_count = '0; v_count = '0;
    @(posedge clock_25); #1; cyc++;
    do_reset(0, 0);

    // 1: idle scan over the field plus a margin
    for (int v = OY - 1; v <= OY + 10; v++)
      for (int h = OX - 2; h <= OX + 2 * PI + 11; h++)
        step(1'b0, 1'b0, h, v);
    step(1'b0, 1'b0, OX + 3, OY + 2);
    step(1'b0, 1'b0, 0, 0);
    chk("t1_sel", 32'(selected_number), 32'd0);
    step(1'b0, 1'b0, 0, 0);

    // 2: counting and carries
    repeat (9) pulse();
    chk("t2_009", 32'(score_bcd), 32'h009);
    pulse();
    chk("t2_010", 32'(score_bcd), 32'h010);
    repeat (89) pulse();
    chk("t2_099", 32'(score_bcd), 32'h099);
    pulse();
    chk("t2_100", 32'(score_bcd), 32'h100);
    repeat (23) pulse();

    // 4: geometry at score 123
    step(1'b0, 1'b0, OX + PI, OY);
    step(1'b0, 1'b0, OX + 2 * PI + 9, OY + 9);
    step(1'b0, 1'b0, OX + 10, OY);
    step(1'b0, 1'b0, OX - 1, OY);
    step(1'b0, 1'b0, OX, OY + 10);
    step(1'b0, 1'b0, OX + 5, OY + 5);
    step(1'b0, 1'b0, OX + PI + 11, OY + 1);
    step(1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 0, 0);

    // 3: held point counts once, then saturation
    repeat (20) step(1'b1, 1'b0, 0, 0);
    step(1'b0, 1'b0, 0, 0);
    chk("t3_held", 32'(score_bcd), 32'h124);
    repeat (875) pulse();
    chk("t3_999", 32'(score_bcd), 32'h999);
    pulse();
    chk("t3_sat", 32'(score_bcd), 32'h999);
    chk("t3_max", 32'(score_max), 32'd1);
    step(1'b0, 1'b0, OX + 2 * PI, OY);
    step(1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 0, 0);

    // 5: clear beats a simultaneous point edge
    step(1'b0, 1'b1, 0, 0);
    step(1'b0, 1'b0, 0, 0);
    repeat (45) pulse();
    chk("t5_045", 32'(score_bcd), 32'h045);
    step(1'b1, 1'b1, 0, 0);
    chk("t5_clr", 32'(score_bcd), 32'h000);
    step(1'b0, 1'b0, 0, 0);
    repeat (3) pulse();

    // 5b: reset mid-field flushes the pipeline
    step(1'b0, 1'b0, OX + 1, OY + 1);
    step(1'b0, 1'b0, OX + 2, OY + 1);
    do_reset(OX + 3, OY + 1);
    step(1'b0, 1'b0, OX + 4, OY + 1);
    step(1'b0, 1'b0, OX + 5, OY + 1);
    step(1'b0, 1'b0, OX + 6, OY + 1);
    step(1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 0, 0);
    repeat (7) pulse();

    // 6: latency walk
    first_drive = -1;
    rise_cyc = -1;
    for (int h = OX - 3; h <= OX + 2 * PI + 12; h++) begin
      if (h == OX) first_drive = cyc;
      step(1'b0, 1'b0, h, OY + 4);
      if (digit_active && rise_cyc < 0) rise_cyc = cyc;
    end
    step(1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 0, 0);
    chk("t6_latency", 32'(rise_cyc - first_drive), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
